// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Desc     : Shared encodings and helpers for the multi-cycle data memory.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True when the size is illegal or the address is not naturally aligned.
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] addr_lo);
        logic fault;
        case (size)
            SZ_B:    fault = 1'b0;
            SZ_H:    fault = addr_lo[0];
            SZ_W:    fault = |addr_lo;
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Desc     : Request/response bus between the memory stage and the data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Desc     : Byte-lane merge for stores and lane extract/extend for loads.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import dmem_pkg::*;
(
    input  wire logic [1:0]  i_size,
    input  wire logic        i_unsigned,
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [31:0] i_old_word,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_store_word,
    output logic      [31:0] o_load_word
);

    logic [31:0] w_shifted;
    logic        w_sign_b;
    logic        w_sign_h;

    always_comb begin
        w_shifted    = i_old_word >> {i_addr_lo, 3'b000};
        w_sign_b     = ~i_unsigned & w_shifted[7];
        w_sign_h     = ~i_unsigned & w_shifted[15];
        o_store_word = i_old_word;
        o_load_word  = w_shifted;
        case (i_size)
            SZ_B: begin
                o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
                o_load_word = {{24{w_sign_b}}, w_shifted[7:0]};
            end
            SZ_H: begin
                o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
                o_load_word = {{16{w_sign_h}}, w_shifted[15:0]};
            end
            default: begin
                o_store_word = i_wdata;
                o_load_word  = w_shifted;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Desc     : Multi-cycle data-memory slave with configurable response latency.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    data_mem_responder_if.slave bus
);

    localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam int         c_AB       = c_IDX_W + 2;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;

    logic              r_we;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [c_AB-1:0]   r_addr;
    logic [31:0]       r_wdata;

    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_err;

    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_op_we;
    logic              w_op_uns;
    logic [1:0]        w_op_size;
    logic [c_AB-1:0]   w_op_addr;
    logic [31:0]       w_op_wdata;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]       w_old_word;
    logic [31:0]       w_store_word;
    logic [31:0]       w_load_word;
    logic              w_fault;
    logic              w_unused_addr;

    assign w_unused_addr = ^bus.req_addr[31:c_AB];
    assign w_accept      = (r_state == IDLE) && bus.req_valid;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_cnt_next = c_CNT_LOAD;
                    w_next     = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With LATENCY==1 the response edge is the accept edge, so operate on the live bus.
    always_comb begin
        if (r_state == IDLE) begin
            w_op_we    = bus.req_we;
            w_op_uns   = bus.req_unsigned;
            w_op_size  = bus.req_size;
            w_op_addr  = bus.req_addr[c_AB-1:0];
            w_op_wdata = bus.req_wdata;
        end else begin
            w_op_we    = r_we;
            w_op_uns   = r_uns;
            w_op_size  = r_size;
            w_op_addr  = r_addr;
            w_op_wdata = r_wdata;
        end
    end

    assign w_idx        = w_op_addr[c_AB-1:2];
    assign w_old_word   = r_mem[w_idx];
    assign w_fault      = access_fault(w_op_size, w_op_addr[1:0]);
    assign w_enter_resp = rst && (w_next == RESP) && (r_state != RESP);

    mem_lane_align u_align (
        .i_size       (w_op_size),
        .i_unsigned   (w_op_uns),
        .i_addr_lo    (w_op_addr[1:0]),
        .i_old_word   (w_old_word),
        .i_wdata      (w_op_wdata),
        .o_store_word (w_store_word),
        .o_load_word  (w_load_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_B;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_size  <= bus.req_size;
                r_addr  <= bus.req_addr[c_AB-1:0];
                r_wdata <= bus.req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= w_enter_resp;
            if (w_enter_resp) begin
                r_resp_err   <= w_fault;
                r_resp_rdata <= (w_fault || w_op_we) ? 32'd0 : w_load_word;
            end
        end
    end

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_op_we && !w_fault) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Desc     : Directed self-checking bench for data_mem_responder (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (64),
        .LATENCY     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Issues one request from IDLE and observes the response window.
    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int busy, output logic dbl);
        lat  = -1;
        busy = 0;
        dbl  = 1'b0;
        rd   = 32'hxxxxxxxx;
        er   = 1'bx;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (!bus.req_ready) busy++;
            if (bus.resp_valid) begin
                if (lat < 0) begin
                    lat = i;
                    rd  = bus.resp_rdata;
                    er  = bus.resp_err;
                end else begin
                    dbl = 1'b1;
                end
            end
            if (bus.req_ready && lat > 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b, want 0/0/0",
                     bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b valid=%b, want 1/0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; logic er, dbl; int lat, busy;
        xact(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, busy, dbl);
        checks++;
        if (lat !== 2 || busy !== 2 || dbl !== 1'b0) begin
            failures++;
            $display("FAIL sw_timing: got lat=%0d busy=%0d extra_pulse=%b, want 2/2/0", lat, busy, dbl);
        end
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            failures++;
            $display("FAIL sw_resp: got rdata=%h err=%b, want 00000000/0", rd, er);
        end
        xact(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (lat !== 2 || busy !== 2 || dbl !== 1'b0) begin
            failures++;
            $display("FAIL lw_timing: got lat=%0d busy=%0d extra_pulse=%b, want 2/2/0", lat, busy, dbl);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            failures++;
            $display("FAIL lw_data: got rdata=%h err=%b, want deadbeef/0", rd, er);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er, dbl; int lat, busy;
        xact(1'b1, SZ_W, 1'b0, 32'h20, 32'h11223344, rd, er, lat, busy, dbl);
        xact(1'b1, SZ_B, 1'b0, 32'h21, 32'h000000AA, rd, er, lat, busy, dbl);
        xact(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'h1122AA44 || er !== 1'b0) begin
            failures++;
            $display("FAIL sb_merge: got rdata=%h err=%b, want 1122aa44/0", rd, er);
        end
        xact(1'b0, SZ_B, 1'b0, 32'h21, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'hFFFFFFAA || er !== 1'b0) begin
            failures++;
            $display("FAIL lb_signed: got rdata=%h err=%b, want ffffffaa/0", rd, er);
        end
        xact(1'b0, SZ_B, 1'b1, 32'h21, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'h000000AA || er !== 1'b0) begin
            failures++;
            $display("FAIL lbu: got rdata=%h err=%b, want 000000aa/0", rd, er);
        end
        xact(1'b0, SZ_B, 1'b1, 32'h23, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'h00000011 || er !== 1'b0) begin
            failures++;
            $display("FAIL lbu_lane3: got rdata=%h err=%b, want 00000011/0", rd, er);
        end
    endtask

    task automatic test_half_lanes();
        logic [31:0] rd; logic er, dbl; int lat, busy;
        xact(1'b1, SZ_H, 1'b0, 32'h22, 32'hFFFF8001, rd, er, lat, busy, dbl);
        xact(1'b0, SZ_H, 1'b0, 32'h22, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'hFFFF8001 || er !== 1'b0) begin
            failures++;
            $display("FAIL lh_signed: got rdata=%h err=%b, want ffff8001/0", rd, er);
        end
        xact(1'b0, SZ_H, 1'b1, 32'h22, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'h00008001 || er !== 1'b0) begin
            failures++;
            $display("FAIL lhu: got rdata=%h err=%b, want 00008001/0", rd, er);
        end
        xact(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'h8001AA44 || er !== 1'b0) begin
            failures++;
            $display("FAIL sh_merge: got rdata=%h err=%b, want 8001aa44/0", rd, er);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er, dbl; int lat, busy;
        xact(1'b0, SZ_W, 1'b0, 32'h13, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1 || lat !== 2) begin
            failures++;
            $display("FAIL lw_misaligned: got rdata=%h err=%b lat=%0d, want 00000000/1/2", rd, er, lat);
        end
        xact(1'b1, SZ_W, 1'b0, 32'h10, 32'h00000000, rd, er, lat, busy, dbl);
        xact(1'b1, SZ_H, 1'b0, 32'h11, 32'h0000FFFF, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            failures++;
            $display("FAIL sh_misaligned: got rdata=%h err=%b, want 00000000/1", rd, er);
        end
        xact(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            failures++;
            $display("FAIL sh_misaligned_nowrite: got rdata=%h err=%b, want 00000000/0", rd, er);
        end
        xact(1'b0, SZ_X, 1'b0, 32'h10, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            failures++;
            $display("FAIL size_illegal: got rdata=%h err=%b, want 00000000/1", rd, er);
        end
        xact(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (er !== 1'b0) begin
            failures++;
            $display("FAIL lh_aligned_noerr: got err=%b, want 0", er);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er, dbl; int lat, busy;
        xact(1'b1, SZ_W, 1'b0, 32'h100, 32'h5A5A5A5A, rd, er, lat, busy, dbl);
        xact(1'b0, SZ_W, 1'b0, 32'h000, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'h5A5A5A5A || er !== 1'b0) begin
            failures++;
            $display("FAIL addr_wrap: got rdata=%h err=%b, want 5a5a5a5a/0", rd, er);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, dbl; int lat, busy;
        logic seen;
        xact(1'b1, SZ_W, 1'b0, 32'h30, 32'h00000000, rd, er, lat, busy, dbl);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h30;
        bus.req_wdata    = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_wait: got ready=%b, want 0", bus.req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_valid: got valid=%b, want 0", bus.resp_valid);
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_ready_after: got ready=%b, want 1", bus.req_ready);
        end
        repeat (4) begin
            if (bus.resp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_pulse: got pulse=%b, want 0", seen);
        end
        xact(1'b0, SZ_W, 1'b0, 32'h30, 32'h0, rd, er, lat, busy, dbl);
        checks++;
        if (rd !== 32'h00000000 || er !== 1'b0) begin
            failures++;
            $display("FAIL mid_store_dropped: got rdata=%h err=%b, want 00000000/0", rd, er);
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_W;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_half_lanes();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory slave. It serves load and store requests from the pipeline memory stage over a valid/ready request channel and a one-cycle response pulse.
- Supports byte, halfword and word accesses with RISC-V lane placement and sign/zero extension.
- Inserts a configurable wait latency; the pipeline stalls while req_ready is low.
- Sits behind the memory stage in place of a fixed single-cycle data memory.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the array; must be a power of 2.
- LATENCY, 2: cycles from request acceptance to the response pulse; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0]).
- req_unsigned  in  1  zero-extend loads (funct3[2]); ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request; qualified by resp_valid.

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE and the wait counter clears to 0.
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 once rst deasserts.
  - The array is NOT reset; contents are undefined until written.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a rising edge, capture we/size/unsigned/addr/wdata into holding registers.
  - Load the counter with LATENCY-1.
  - Next state: RESP if LATENCY==1, else WAIT.
- WAIT:
  - req_ready=0; inputs are ignored.
  - Decrement the counter each cycle.
  - When the counter reaches 1, the next edge enters RESP.
- Timing:
  - Acceptance at edge k gives resp_valid high during cycle k+LATENCY, for exactly one cycle.
  - Next acceptance is possible at edge k+LATENCY+1.
  - Throughput: one request per LATENCY+1 cycles.
- Edge entering RESP:
  - Store: merge the data into the array.
  - Load: read the array and register the extended result into resp_rdata.
  - Error is computed from the captured fields.
- RESP:
  - req_ready=0.
  - The next edge returns to IDLE and clears resp_valid.
  - resp_rdata and resp_err hold until the next response.
- Indexing:
  - word index = addr[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=00; size 11 is always an error.
  - An error suppresses the write, forces resp_rdata=0, sets resp_err=1, and keeps the normal latency.
- Store lanes:
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lane addr[1].
  - Other lanes are unchanged.
- Load lanes:
  - Extract the selected lane and shift it to bit 0.
  - Sign-extend if req_unsigned=0, zero-extend if 1.
- Read-after-write: a load accepted after a store's response observes the stored data.
- Reset mid-operation (in WAIT or RESP):
  - The pending store is discarded if the write edge has not occurred.
  - No resp_valid is produced for the aborted request.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - FSM state encoding IDLE/WAIT/RESP.
  - A function for misalignment check.
- One combinational sub-module mem_lane_align. It takes (size, unsigned, addr[1:0], old_word, wdata) and outputs the merged store word and the extended load word.
- The FSM, counter and array live in the top module.

Test Plan:
- LATENCY=2, store word 0xDEADBEEF @0x10, then load word @0x10.
  - req_ready low 2 cycles after each accept.
  - resp_valid at accept+2, for one cycle.
  - rdata=0xDEADBEEF, err=0.
- After word 0x11223344 @0x20:
  - Store byte 0xAA @0x21; load word @0x20 gives 0x1122AA44.
  - Load signed byte @0x21 gives 0xFFFFFFAA.
  - Load unsigned byte @0x21 gives 0x000000AA.
- Store half 0x8001 @0x22; load signed half @0x22 gives 0xFFFF8001; load unsigned half gives 0x00008001.
- Misalignment errors:
  - Load word @0x13: err=1, rdata=0.
  - Store half @0x11 with prior word 0x0 @0x10: err=1, and a later load of @0x10 returns 0x0.
  - size=11: err=1.
- Wrap-around with DEPTH_WORDS=64: store word 0x5A5A5A5A @0x100, then load @0x000 gives 0x5A5A5A5A.
- Reset mid-operation:
  - Accept store 0x12345678 @0x30 after word 0 was written there.
  - Pull rst low during WAIT: immediately resp_valid=0 and no pulse follows.
  - After release, req_ready=1 and a load of @0x30 returns 0x00000000.
